line_buffer_window: RTL and testbench



---
 rtl/img_pkg.sv | 20 ++
 rtl/line_buffer_ram.sv | 35 +++
 rtl/line_buffer_window.sv | 127 ++++++++++++
 tb/tb_line_buffer_window.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : img_pkg
//  Description : Shared pixel type and default frame geometry for the
//                image-processing pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package img_pkg;

    // Default pixel depth used across the pipeline
    localparam int c_PIXEL_WIDTH = 8;

    // Default frame geometry (VGA)
    localparam int c_ROW_WIDTH   = 640;
    localparam int c_ROW_COUNT   = 480;

    typedef logic [c_PIXEL_WIDTH-1:0] pixel_t;

endpackage
`default_nettype wire

// File: rtl/line_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer_ram
//  Description : Single-port row memory holding all K-1 line buffers side by
//                side in one word. Combinational read, synchronous write, so
//                a read and a write at the same address in one cycle return
//                the old contents (read-before-write).
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buffer_ram
    import img_pkg::*;
#(
    parameter int DEPTH      = c_ROW_WIDTH,
    parameter int DATA_WIDTH = 2 * c_PIXEL_WIDTH
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    // Write the shifted column back into the row memory
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/line_buffer_window.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer_window
//  Description : Streaming KxK neighbourhood generator. Keeps K-1 row
//                buffers plus a KxK register window and strobes out_valid
//                only for windows lying wholly inside the image, together
//                with the window-centre coordinates.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buffer_window
    import img_pkg::*;
#(
    parameter int PIXEL_WIDTH = c_PIXEL_WIDTH,
    parameter int KERNEL_SIZE = 3,
    parameter int ROW_WIDTH   = c_ROW_WIDTH,
    parameter int ROW_COUNT   = c_ROW_COUNT
) (
    input  logic                                                    clk,
    input  logic                                                    reset_n,
    input  logic [PIXEL_WIDTH-1:0]                                  pixel_in,
    input  logic                                                    in_valid,
    input  logic                                                    sof,
    output logic [KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][PIXEL_WIDTH-1:0] window,
    output logic                                                    out_valid,
    output logic [$clog2(ROW_COUNT)-1:0]                            out_row,
    output logic [$clog2(ROW_WIDTH)-1:0]                            out_col
);

    localparam int c_ROW_BITS = $clog2(ROW_COUNT);
    localparam int c_COL_BITS = $clog2(ROW_WIDTH);
    localparam int c_LB_WIDTH = PIXEL_WIDTH * (KERNEL_SIZE - 1);

    localparam logic [c_ROW_BITS-1:0] c_ROW_LAST = c_ROW_BITS'(ROW_COUNT - 1);
    localparam logic [c_COL_BITS-1:0] c_COL_LAST = c_COL_BITS'(ROW_WIDTH - 1);
    localparam logic [c_ROW_BITS-1:0] c_ROW_EDGE = c_ROW_BITS'(KERNEL_SIZE - 1);
    localparam logic [c_COL_BITS-1:0] c_COL_EDGE = c_COL_BITS'(KERNEL_SIZE - 1);
    localparam logic [c_ROW_BITS-1:0] c_ROW_HALF = c_ROW_BITS'((KERNEL_SIZE - 1) / 2);
    localparam logic [c_COL_BITS-1:0] c_COL_HALF = c_COL_BITS'((KERNEL_SIZE - 1) / 2);

    logic [c_ROW_BITS-1:0] r_row_cnt;
    logic [c_COL_BITS-1:0] r_col_cnt;
    logic [c_ROW_BITS-1:0] w_row;
    logic [c_COL_BITS-1:0] w_col;
    logic [c_ROW_BITS-1:0] w_row_nxt;
    logic [c_COL_BITS-1:0] w_col_nxt;
    logic                  w_win_ok;

    logic [c_LB_WIDTH-1:0]                   w_lb_rdata;
    logic [c_LB_WIDTH-1:0]                   w_lb_wdata;
    logic [KERNEL_SIZE-1:0][PIXEL_WIDTH-1:0] w_new_col;

    // A start-of-frame pixel always sits at (0,0), whatever the counters say
    assign w_row = sof ? '0 : r_row_cnt;
    assign w_col = sof ? '0 : r_col_cnt;

    // Only a window whose bottom-right pixel is at least K-1 rows and columns
    // into the frame lies wholly inside the image; this masks both the
    // previous-row columns at a row start and stale rows after a frame wrap.
    assign w_win_ok = (w_row >= c_ROW_EDGE) && (w_col >= c_COL_EDGE);

    // Each buffer passes its old pixel one buffer up (towards index 0, the
    // oldest row); the newest buffer takes the incoming pixel.
    assign w_lb_wdata = {pixel_in, w_lb_rdata[c_LB_WIDTH-1:PIXEL_WIDTH]};

    // New right-hand column, oldest row at index 0, live pixel at the bottom
    assign w_new_col = {pixel_in, w_lb_rdata};

    // Raster position of the next pixel
    always_comb begin
        w_col_nxt = w_col + 1'b1;
        w_row_nxt = w_row;
        if (w_col == c_COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = (w_row == c_ROW_LAST) ? '0 : w_row + 1'b1;
        end
    end

    // Row/column counters advance on every accepted pixel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_row_cnt <= '0;
            r_col_cnt <= '0;
        end else if (in_valid) begin
            r_row_cnt <= w_row_nxt;
            r_col_cnt <= w_col_nxt;
        end
    end

    line_buffer_ram #(
        .DEPTH      (ROW_WIDTH),
        .DATA_WIDTH (c_LB_WIDTH)
    ) u_line_buffer_ram (
        .clk     (clk),
        .i_we    (in_valid),
        .i_addr  (w_col),
        .i_wdata (w_lb_wdata),
        .o_rdata (w_lb_rdata)
    );

    // Shift the window one column left and load the new column on the right
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            window <= '0;
        end else if (in_valid) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
                window[r] <= {w_new_col[r], window[r][KERNEL_SIZE-1:1]};
            end
        end
    end

    // Single-cycle valid strobe and centre coordinates of a complete window
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            out_valid <= in_valid && w_win_ok;
            if (in_valid && w_win_ok) begin
                out_row <= w_row - c_ROW_HALF;
                out_col <= w_col - c_COL_HALF;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_window.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_buffer_window
//  Description : Self-checking bench for line_buffer_window. Instance A is
//                K=3 on an 8x6 frame, instance B is K=5 / 10-bit on 16x8.
//                Expected windows come from an image-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_line_buffer_window;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    // Instance A: K=3, 8-bit, 8x6
    logic [7:0]             a_pix   = '0;
    logic                   a_valid = 1'b0;
    logic                   a_sof   = 1'b0;
    logic [2:0][2:0][7:0]   a_win;
    logic                   a_ov;
    logic [2:0]             a_orow;
    logic [2:0]             a_ocol;

    line_buffer_window #(
        .PIXEL_WIDTH(8), .KERNEL_SIZE(3), .ROW_WIDTH(8), .ROW_COUNT(6)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .pixel_in(a_pix), .in_valid(a_valid),
        .sof(a_sof), .window(a_win), .out_valid(a_ov), .out_row(a_orow),
        .out_col(a_ocol)
    );

    // Instance B: K=5, 10-bit, 16x8
    logic [9:0]             b_pix   = '0;
    logic                   b_valid = 1'b0;
    logic                   b_sof   = 1'b0;
    logic [4:0][4:0][9:0]   b_win;
    logic                   b_ov;
    logic [2:0]             b_orow;
    logic [3:0]             b_ocol;

    line_buffer_window #(
        .PIXEL_WIDTH(10), .KERNEL_SIZE(5), .ROW_WIDTH(16), .ROW_COUNT(8)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .pixel_in(b_pix), .in_valid(b_valid),
        .sof(b_sof), .window(b_win), .out_valid(b_ov), .out_row(b_orow),
        .out_col(b_ocol)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: last pixel written at each image position
    int          a_img [6][8];
    int          a_r = 0, a_c = 0, a_cnt = 0;
    logic        a_ev;
    logic [77:0] a_exp;

    int          b_img [8][16];
    int          b_r = 0, b_c = 0, b_cnt = 0;
    logic        b_ev;
    logic [256:0] b_exp;

    // Expected k-th strobe of a ramp frame (pixel = row*16 + col) on A
    function automatic logic [77:0] ramp_exp(input int k);
        logic [2:0][2:0][7:0] w;
        int r, c;
        r = 2 + k / 6;
        c = 2 + k % 6;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i][j] = 8'((r - 2 + i) * 16 + (c - 2 + j));
        return {w, 3'(r - 1), 3'(c - 1)};
    endfunction

    task automatic a_step(input logic [7:0] pix, input logic v, input logic s);
        logic [2:0][2:0][7:0] w;
        a_pix = pix; a_valid = v; a_sof = s;
        @(posedge clk); #1;
        a_valid = 1'b0; a_sof = 1'b0;
        a_ev = 1'b0;
        if (v) begin
            if (s) begin a_r = 0; a_c = 0; end
            a_img[a_r][a_c] = int'(pix);
            if (a_r >= 2 && a_c >= 2) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        w[i][j] = 8'(a_img[a_r - 2 + i][a_c - 2 + j]);
                a_ev  = 1'b1;
                a_exp = {w, 3'(a_r - 1), 3'(a_c - 1)};
            end
            a_c++;
            if (a_c == 8) begin a_c = 0; a_r = (a_r == 5) ? 0 : a_r + 1; end
        end
        if (a_ov) a_cnt++;
    endtask

    task automatic b_step(input logic [9:0] pix, input logic v, input logic s);
        logic [4:0][4:0][9:0] w;
        b_pix = pix; b_valid = v; b_sof = s;
        @(posedge clk); #1;
        b_valid = 1'b0; b_sof = 1'b0;
        b_ev = 1'b0;
        if (v) begin
            if (s) begin b_r = 0; b_c = 0; end
            b_img[b_r][b_c] = int'(pix);
            if (b_r >= 4 && b_c >= 4) begin
                for (int i = 0; i < 5; i++)
                    for (int j = 0; j < 5; j++)
                        w[i][j] = 10'(b_img[b_r - 4 + i][b_c - 4 + j]);
                b_ev  = 1'b1;
                b_exp = {w, 3'(b_r - 2), 4'(b_c - 2)};
            end
            b_c++;
            if (b_c == 16) begin b_c = 0; b_r = (b_r == 7) ? 0 : b_r + 1; end
        end
        if (b_ov) b_cnt++;
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if (a_win !== '0 || a_ov !== 1'b0 || a_orow !== '0 || a_ocol !== '0)
            $display("FAIL reset_a: win=%h ov=%b row=%0d col=%0d required all zero", a_win, a_ov, a_orow, a_ocol);
        else n_pass++;
        n_total++;
        if (b_win !== '0 || b_ov !== 1'b0 || b_orow !== '0 || b_ocol !== '0)
            $display("FAIL reset_b: win=%h ov=%b row=%0d col=%0d required all zero", b_win, b_ov, b_orow, b_ocol);
        else n_pass++;
        @(posedge clk); @(posedge clk); #2;
        reset_n = 1'b1;
        a_r = 0; a_c = 0; b_r = 0; b_c = 0;
    endtask

    task automatic test_ramp_frame();
        logic [2:0][2:0][7:0] w_exp;
        logic [7:0] pix;
        logic [7:0] last_br = '0;
        int first_pix = -1, last_r = 0, last_c = 0;
        a_cnt = 0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 8; c++) begin
                pix = 8'(r * 16 + c);
                a_step(pix, 1'b1, (r == 0 && c == 0));
                n_total++;
                if (a_ov !== a_ev) $display("FAIL ramp_valid: got %b required %b at pixel %h", a_ov, a_ev, pix);
                else n_pass++;
                if (a_ov) begin
                    n_total++;
                    if ({a_win, a_orow, a_ocol} !== ramp_exp(a_cnt - 1))
                        $display("FAIL ramp_window: got %h required %h", {a_win, a_orow, a_ocol}, ramp_exp(a_cnt - 1));
                    else n_pass++;
                    if (first_pix < 0) first_pix = r * 16 + c;
                    last_r = int'(a_orow); last_c = int'(a_ocol); last_br = a_win[2][2];
                end
                if (pix == 8'h22) begin
                    w_exp = 72'h22_21_20_12_11_10_02_01_00;
                    n_total++;
                    if (a_win !== w_exp || a_orow !== 3'd1 || a_ocol !== 3'd1)
                        $display("FAIL first_window: got %h (%0d,%0d) required %h (1,1)", a_win, a_orow, a_ocol, w_exp);
                    else n_pass++;
                end
                if (pix == 8'h30 || pix == 8'h31) begin
                    n_total++;
                    if (a_ov !== 1'b0) $display("FAIL row_edge_valid: got %b required 0 at pixel %h", a_ov, pix);
                    else n_pass++;
                end
                if (pix == 8'h32) begin
                    w_exp = 72'h32_31_30_22_21_20_12_11_10;
                    n_total++;
                    if (a_win !== w_exp) $display("FAIL row_edge_window: got %h required %h", a_win, w_exp);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (a_cnt !== 24) $display("FAIL ramp_count: got %0d required 24", a_cnt);
        else n_pass++;
        n_total++;
        if (first_pix !== 34) $display("FAIL ramp_first: got pixel %h required 22", first_pix);
        else n_pass++;
        n_total++;
        if (last_r !== 4 || last_c !== 6 || last_br !== 8'h57)
            $display("FAIL ramp_last: got (%0d,%0d) br=%h required (4,6) br=57", last_r, last_c, last_br);
        else n_pass++;
    endtask

    task automatic test_idle_hold();
        logic [77:0] e;
        logic [71:0] w_exp;
        e = ramp_exp(23);
        w_exp = e[77:6];
        for (int k = 0; k < 3; k++) begin
            a_step(8'hAA, 1'b0, 1'b0);
            n_total++;
            if (a_ov !== 1'b0 || a_win !== w_exp)
                $display("FAIL idle_hold: ov=%b win=%h required ov=0 win=%h", a_ov, a_win, w_exp);
            else n_pass++;
        end
    endtask

    task automatic test_gaps();
        logic [7:0] pix;
        a_cnt = 0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 8; c++) begin
                repeat ($urandom_range(3, 0)) begin
                    a_step(8'(r * 16 + c + 1), 1'b0, 1'b0);
                    n_total++;
                    if (a_ov !== 1'b0) $display("FAIL gap_idle_valid: got %b required 0", a_ov);
                    else n_pass++;
                end
                pix = 8'(r * 16 + c);
                a_step(pix, 1'b1, (r == 0 && c == 0));
                n_total++;
                if (a_ov !== a_ev) $display("FAIL gap_valid: got %b required %b at pixel %h", a_ov, a_ev, pix);
                else n_pass++;
                if (a_ov) begin
                    n_total++;
                    if ({a_win, a_orow, a_ocol} !== ramp_exp(a_cnt - 1))
                        $display("FAIL gap_window: got %h required %h", {a_win, a_orow, a_ocol}, ramp_exp(a_cnt - 1));
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (a_cnt !== 24) $display("FAIL gap_count: got %0d required 24", a_cnt);
        else n_pass++;
    endtask

    task automatic test_random_frame();
        a_cnt = 0;
        for (int p = 0; p < 48; p++) begin
            if ($urandom_range(1, 0) == 1) a_step(8'($urandom), 1'b0, 1'b0);
            a_step(8'($urandom), 1'b1, (p == 0));
            n_total++;
            if (a_ov !== a_ev) $display("FAIL rand_valid: got %b required %b at index %0d", a_ov, a_ev, p);
            else n_pass++;
            if (a_ev) begin
                n_total++;
                if ({a_win, a_orow, a_ocol} !== a_exp)
                    $display("FAIL rand_window: got %h required %h", {a_win, a_orow, a_ocol}, a_exp);
                else n_pass++;
            end
        end
        n_total++;
        if (a_cnt !== 24) $display("FAIL rand_count: got %0d required 24", a_cnt);
        else n_pass++;
    endtask

    task automatic test_mid_sof();
        logic all_new;
        for (int p = 0; p <= 8'h45; p++) begin
            if ((p % 16) < 8) a_step(8'(p), 1'b1, (p == 0));
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 8; c++) begin
                a_step(8'(8'h80 + r * 16 + c), 1'b1, (r == 0 && c == 0));
                n_total++;
                if (a_ov !== a_ev) $display("FAIL msof_valid: got %b required %b at (%0d,%0d)", a_ov, a_ev, r, c);
                else n_pass++;
                if (a_ev) begin
                    n_total++;
                    if ({a_win, a_orow, a_ocol} !== a_exp)
                        $display("FAIL msof_window: got %h required %h", {a_win, a_orow, a_ocol}, a_exp);
                    else n_pass++;
                end
                if (r < 2 || (r == 2 && c < 2)) begin
                    n_total++;
                    if (a_ov !== 1'b0) $display("FAIL msof_early: got %b required 0 at (%0d,%0d)", a_ov, r, c);
                    else n_pass++;
                end
                if (r == 2 && c == 2) begin
                    all_new = 1'b1;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            if (a_win[i][j] < 8'h80) all_new = 1'b0;
                    n_total++;
                    if (a_ov !== 1'b1 || all_new !== 1'b1)
                        $display("FAIL msof_first: ov=%b win=%h required ov=1 and only new-frame pixels", a_ov, a_win);
                    else n_pass++;
                end
            end
        end
    endtask

    task automatic test_async_reset();
        for (int p = 0; p <= 8'h23; p++) begin
            if ((p % 16) < 8) a_step(8'(p), 1'b1, (p == 0));
        end
        n_total++;
        if (a_ov !== 1'b1) $display("FAIL pre_reset_valid: got %b required 1", a_ov);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if (a_win !== '0 || a_ov !== 1'b0)
            $display("FAIL async_reset: win=%h ov=%b required zero", a_win, a_ov);
        else n_pass++;
        @(posedge clk); #2;
        reset_n = 1'b1;
        a_r = 0; a_c = 0; b_r = 0; b_c = 0;
        a_cnt = 0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 8; c++) begin
                a_step(8'(r * 16 + c), 1'b1, (r == 0 && c == 0));
                n_total++;
                if (a_ov !== a_ev) $display("FAIL rst_valid: got %b required %b at (%0d,%0d)", a_ov, a_ev, r, c);
                else n_pass++;
                if (a_ov) begin
                    n_total++;
                    if ({a_win, a_orow, a_ocol} !== ramp_exp(a_cnt - 1))
                        $display("FAIL rst_window: got %h required %h", {a_win, a_orow, a_ocol}, ramp_exp(a_cnt - 1));
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (a_cnt !== 24) $display("FAIL rst_count: got %0d required 24", a_cnt);
        else n_pass++;
    endtask

    task automatic test_k5(input logic rnd);
        logic [9:0] pix;
        logic first_done = 1'b0;
        b_cnt = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 16; c++) begin
                if (rnd) begin
                    pix = 10'($urandom);
                    if ($urandom_range(2, 0) == 0) b_step(10'h0, 1'b0, 1'b0);
                end else begin
                    pix = (r == 2 && c == 2) ? 10'h155 : 10'h3FF;
                end
                b_step(pix, 1'b1, (r == 0 && c == 0));
                n_total++;
                if (b_ov !== b_ev) $display("FAIL k5_valid: got %b required %b at (%0d,%0d)", b_ov, b_ev, r, c);
                else n_pass++;
                if (b_ev) begin
                    n_total++;
                    if ({b_win, b_orow, b_ocol} !== b_exp)
                        $display("FAIL k5_window: got %h required %h", {b_win, b_orow, b_ocol}, b_exp);
                    else n_pass++;
                end
                if (!rnd && b_ov && !first_done) begin
                    first_done = 1'b1;
                    n_total++;
                    if (r !== 4 || c !== 4 || b_win[2][2] !== 10'h155 || b_orow !== 3'd2 || b_ocol !== 4'd2)
                        $display("FAIL k5_first: at (%0d,%0d) centre=%h (%0d,%0d) required (4,4) centre=155 (2,2)",
                                 r, c, b_win[2][2], b_orow, b_ocol);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (b_cnt !== 48) $display("FAIL k5_count: got %0d required 48", b_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ramp_frame();
        test_idle_hold();
        test_gaps();
        test_random_frame();
        test_mid_sof();
        test_async_reset();
        test_k5(1'b0);
        test_k5(1'b1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
